// File: rtl/median_pkg.sv
// Shared definitions for the 5-tap streaming median filter.
package median_pkg;
    localparam int SAMPLE_W = 6;
    localparam int TAPS     = 5;
    localparam int IDX_W    = 3;

    typedef enum logic {FILL, RUN} state_t;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/median_stream_5_if.sv
// Valid/ready stream bundle: sample input side and median output side.
interface median_stream_5_if #(parameter int WIDTH = median_pkg::SAMPLE_W);
    import median_pkg::*;

    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [IDX_W-1:0] m_index;
    logic             m_ready;

    modport slave  (input  s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data, m_index);
    modport master (output s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data, m_index);
endinterface

// File: rtl/median5_rank.sv
// Pairwise ranking of a 5-entry window; returns the position holding rank 2.
module median5_rank
    import median_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic [WIDTH-1:0] win [TAPS],
    output logic [IDX_W-1:0] med_idx
);
    logic [IDX_W-1:0] rank [TAPS];

    // Equal values: lower position ranks smaller, so ranks are a permutation of 0..4.
    always_comb begin
        med_idx = '0;
        for (int i = 0; i < TAPS; i++) begin
            rank[i] = '0;
            for (int j = 0; j < TAPS; j++) begin
                if (j != i) begin
                    if ((win[j] < win[i]) || ((win[j] == win[i]) && (j < i)))
                        rank[i] = rank[i] + 3'd1;
                end
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            if (rank[i] == 3'd2)
                med_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/median_stream_5.sv
// Streaming 5-tap median: shift window, fill/run FSM and registered output.
//   state | meaning
//   FILL  | fewer than 5 valid window entries, no output produced
//   RUN   | window full, every accepted sample yields one median
module median_stream_5
    import median_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int TAPS  = median_pkg::TAPS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    median_stream_5_if.slave   bus
);
    state_t           state;
    logic [IDX_W-1:0] fill_cnt;
    logic [WIDTH-1:0] win     [TAPS];
    logic [WIDTH-1:0] win_nxt [TAPS];
    logic [IDX_W-1:0] med_idx;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic [IDX_W-1:0] m_index_q;
    logic             accept;
    logic             produce;

    assign bus.s_ready = (!m_valid_q || bus.m_ready) && !flush;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_index = m_index_q;

    assign accept  = bus.s_valid && bus.s_ready;
    assign produce = accept && ((state == RUN) || (fill_cnt == IDX_W'(TAPS - 1)));

    // Median is taken over the window as it will look after this acceptance.
    always_comb begin
        for (int i = 0; i < TAPS - 1; i++)
            win_nxt[i] = win[i + 1];
        win_nxt[TAPS-1] = bus.s_data;
    end

    median5_rank #(.WIDTH(WIDTH)) u_rank (
        .win     (win_nxt),
        .med_idx (med_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            for (int i = 0; i < TAPS; i++)
                win[i] <= '0;
        end else if (flush) begin
            state     <= FILL;
            fill_cnt  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < TAPS; i++)
                    win[i] <= win_nxt[i];
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 3'd1;
                        if (fill_cnt == IDX_W'(TAPS - 1))
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
            if (produce) begin
                m_valid_q <= 1'b1;
                m_data_q  <= win_nxt[med_idx];
                m_index_q <= med_idx;
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_median_stream_5.sv
// Self-checking bench for median_stream_5 against a sorted-window reference.
module tb_median_stream_5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    median_stream_5_if #(.WIDTH(6)) bus ();

    median_stream_5 #(.WIDTH(6), .TAPS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int q[$];
    bit exp_valid = 1'b0;
    int exp_data  = 0;
    int exp_idx   = 0;

    // Stable sort of (value, position); the middle element is the median.
    task automatic model_median();
        int v[5];
        int p[5];
        int tv, tp;
        for (int i = 0; i < 5; i++) begin v[i] = q[i]; p[i] = i; end
        for (int i = 1; i < 5; i++) begin
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
                tp = p[j]; p[j] = p[j-1]; p[j-1] = tp;
            end
        end
        exp_data = v[2];
        exp_idx  = p[2];
    endtask

    function automatic bit exp_ready();
        return (!exp_valid || bus.m_ready) && !flush;
    endfunction

    task automatic set_in(input bit v, input int d, input bit mr, input bit fl);
        bus.s_valid = v;
        bus.s_data  = 6'(d);
        bus.m_ready = mr;
        flush       = fl;
    endtask

    // Advance one clock and update the reference with what the DUT should have done.
    task automatic tick();
        bit acc;
        acc = bus.s_valid && exp_ready();
        @(posedge clk);
        if (flush) begin
            q.delete();
            exp_valid = 1'b0;
        end else begin
            if (acc) begin
                q.push_back(int'(bus.s_data));
                if (q.size() > 5) void'(q.pop_front());
            end
            if (acc && q.size() == 5) begin
                exp_valid = 1'b1;
                model_median();
            end else if (exp_valid && bus.m_ready) begin
                exp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 33, 1'b1, 1'b0);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.m_valid !== 1'b0 || bus.m_data !== 6'd0 || bus.m_index !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b data=%0d idx=%0d, want 0/0/0",
                         bus.m_valid, bus.m_data, bus.m_index);
            end
            n_tests++;
            if (bus.s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_s_ready: got %b want 1", bus.s_ready);
            end
        end
        set_in(1'b0, 0, 1'b1, 1'b0);
        #2 rst_n = 1'b1;
        q.delete();
        exp_valid = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        int seq[5] = '{10, 3, 7, 1, 9};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, seq[i], 1'b1, 1'b0);
            tick();
            if (i < 4) begin
                n_tests++;
                if (bus.m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_no_output[%0d]: got m_valid=%b want 0", i, bus.m_valid);
                end
            end
        end
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd7 || bus.m_index !== 3'd2) begin
            n_fail++;
            $display("FAIL first_median: got valid=%b data=%0d idx=%0d, want 1/7/2",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
        set_in(1'b1, 0, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd3 || bus.m_index !== 3'd0) begin
            n_fail++;
            $display("FAIL median_after_0: got valid=%b data=%0d idx=%0d, want 1/3/0",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
        set_in(1'b1, 63, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd7 || bus.m_index !== 3'd0) begin
            n_fail++;
            $display("FAIL median_after_63: got valid=%b data=%0d idx=%0d, want 1/7/0",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
        set_in(1'b0, 0, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop_after_transfer: got %b want 0", bus.m_valid);
        end
    endtask

    task automatic test_ties();
        int s1[5] = '{5, 5, 5, 2, 8};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, s1[i], 1'b1, 1'b0);
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd5 || bus.m_index !== 3'd1) begin
            n_fail++;
            $display("FAIL ties_55528: got valid=%b data=%0d idx=%0d, want 1/5/1",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 4, 1'b1, 1'b0);
            tick();
        end
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd4 || bus.m_index !== 3'd2) begin
            n_fail++;
            $display("FAIL ties_all4: got valid=%b data=%0d idx=%0d, want 1/4/2",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] held;
        held = bus.m_data;
        set_in(1'b1, 20, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_s_ready: got %b want 0", bus.s_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0d, want 1/%0d",
                         c, bus.m_valid, bus.m_data, held);
            end
        end
        set_in(1'b0, 0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 20, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 6'(exp_data) || bus.m_index !== 3'(exp_idx)
            || exp_data != 4 || exp_idx != 2) begin
            n_fail++;
            $display("FAIL bp_window_unchanged: got valid=%b data=%0d idx=%0d, want 1/4/2",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
    endtask

    task automatic test_flush();
        set_in(1'b1, 50, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_s_ready: got %b want 0", bus.s_ready);
        end
        tick();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clears_valid: got %b want 0", bus.m_valid);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, int'($urandom_range(0, 63)), 1'b1, 1'b0);
            tick();
            n_tests++;
            if (bus.m_valid !== (i == 4)) begin
                n_fail++;
                $display("FAIL flush_refill[%0d]: got m_valid=%b want %b", i, bus.m_valid, (i == 4));
            end
        end
        n_tests++;
        if (bus.m_data !== 6'(exp_data) || bus.m_index !== 3'(exp_idx)) begin
            n_fail++;
            $display("FAIL flush_first_median: got data=%0d idx=%0d, want %0d/%0d",
                     bus.m_data, bus.m_index, exp_data, exp_idx);
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 12, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        n_tests++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got m_valid=%b want 1", bus.m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 6'd0 || bus.m_index !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got valid=%b data=%0d idx=%0d, want 0/0/0",
                     bus.m_valid, bus.m_data, bus.m_index);
        end
        #1 rst_n = 1'b1;
        q.delete();
        exp_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, int'($urandom_range(0, 63)), 1'b1, 1'b0);
            tick();
            n_tests++;
            if (bus.m_valid !== (i == 4)) begin
                n_fail++;
                $display("FAIL areset_refill[%0d]: got m_valid=%b want %b", i, bus.m_valid, (i == 4));
            end
        end
        n_tests++;
        if (bus.m_data !== 6'(exp_data) || bus.m_index !== 3'(exp_idx)) begin
            n_fail++;
            $display("FAIL areset_first_median: got data=%0d idx=%0d, want %0d/%0d",
                     bus.m_data, bus.m_index, exp_data, exp_idx);
        end
    endtask

    task automatic test_random();
        int d;
        for (int c = 0; c < 400; c++) begin
            d = (c % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
            set_in(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 39) == 0));
            #1;
            n_tests++;
            if (bus.s_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_s_ready[%0d]: got %b want %b", c, bus.s_ready, exp_ready());
            end
            tick();
            n_tests++;
            if (bus.m_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_m_valid[%0d]: got %b want %b", c, bus.m_valid, exp_valid);
            end else if (exp_valid && (bus.m_data !== 6'(exp_data) || bus.m_index !== 3'(exp_idx))) begin
                n_fail++;
                $display("FAIL rand_median[%0d]: got data=%0d idx=%0d, want %0d/%0d",
                         c, bus.m_data, bus.m_index, exp_data, exp_idx);
            end
        end
        set_in(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_ties();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
